// File: rtl/board_io_ctrl_if.sv
// Board-facing signal bundle for board_io_ctrl: raw pads in, debounced levels and reset controls out.
// The master side drives the pads; the slave side is the controller.
interface board_io_ctrl_if #(
    parameter int NUM_IN = 10
);
    logic              pad_reset_n_i;
    logic              clk_locked_i;
    logic [NUM_IN-1:0] btn_i;
    logic [NUM_IN-1:0] btn_db_o;
    logic [NUM_IN-1:0] btn_rise_o;
    logic              soc_rst_no;
    logic              sd_pwr_no;
    logic [1:0]        state_o;

    modport master (
        output pad_reset_n_i,
        output clk_locked_i,
        output btn_i,
        input  btn_db_o,
        input  btn_rise_o,
        input  soc_rst_no,
        input  sd_pwr_no,
        input  state_o
    );

    modport slave (
        input  pad_reset_n_i,
        input  clk_locked_i,
        input  btn_i,
        output btn_db_o,
        output btn_rise_o,
        output soc_rst_no,
        output sd_pwr_no,
        output state_o
    );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O controller: synchronizes and debounces buttons, and sequences SD power and SoC reset
// release from the board reset button and the clock-generator lock.
module board_io_ctrl #(
    parameter int NUM_IN          = 10,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int SD_PWR_DELAY    = 1000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    board_io_ctrl_if.slave  io
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES);
    localparam int DLY_W  = $clog2(SD_PWR_DELAY);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(SD_PWR_DELAY - 1);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SD_PWR = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    logic [NUM_IN-1:0] r_btn_meta;
    logic [NUM_IN-1:0] r_btn_sync;
    logic              r_pad_meta;
    logic              r_pad_sync;
    logic              r_lock_meta;
    logic              r_lock_sync;

    logic [DB_W-1:0]   r_db_cnt [NUM_IN];
    logic [NUM_IN-1:0] r_db;
    logic [NUM_IN-1:0] r_rise;

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [DLY_W-1:0]  r_dly_cnt;
    logic              r_soc_rst_n;
    logic              r_sd_pwr_n;

    logic              w_ok;

    // Synchronizers clear to 0 so the pad reset reads as asserted straight out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btn_meta  <= '0;
            r_btn_sync  <= '0;
            r_pad_meta  <= 1'b0;
            r_pad_sync  <= 1'b0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_btn_meta  <= io.btn_i;
            r_btn_sync  <= r_btn_meta;
            r_pad_meta  <= io.pad_reset_n_i;
            r_pad_sync  <= r_pad_meta;
            r_lock_meta <= io.clk_locked_i;
            r_lock_sync <= r_lock_meta;
        end
    end

    // Per-channel debounce; the rise pulse is raised on the same edge that accepts a new 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_db   <= '0;
            r_rise <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_rise[i] <= 1'b0;
                if (r_btn_sync[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_btn_sync[i];
                    r_db_cnt[i] <= '0;
                    r_rise[i]   <= r_btn_sync[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_ok = r_pad_sync & r_lock_sync;

    // Reset sequencer; SD power is sticky-on until rst_i, while SoC reset follows RUN exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_dly_cnt   <= '0;
            r_soc_rst_n <= 1'b0;
            r_sd_pwr_n  <= 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_soc_rst_n <= 1'b0;
                    if (!w_ok) begin
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state    <= ST_SD_PWR;
                        r_hold_cnt <= '0;
                        r_dly_cnt  <= '0;
                        r_sd_pwr_n <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_SD_PWR: begin
                    r_sd_pwr_n <= 1'b0;
                    if (!w_ok) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= '0;
                        r_dly_cnt  <= '0;
                    end else if (r_dly_cnt == DLY_LAST) begin
                        r_state     <= ST_RUN;
                        r_dly_cnt   <= '0;
                        r_soc_rst_n <= 1'b1;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + DLY_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_ok) begin
                        r_state     <= ST_HOLD;
                        r_hold_cnt  <= '0;
                        r_dly_cnt   <= '0;
                        r_soc_rst_n <= 1'b0;
                    end else begin
                        r_soc_rst_n <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_HOLD;
                    r_hold_cnt  <= '0;
                    r_dly_cnt   <= '0;
                    r_soc_rst_n <= 1'b0;
                end
            endcase
        end
    end

    assign io.btn_db_o   = r_db;
    assign io.btn_rise_o = r_rise;
    assign io.soc_rst_no = r_soc_rst_n;
    assign io.sd_pwr_no  = r_sd_pwr_n;
    assign io.state_o    = r_state;

endmodule

// File: doc/board_io_ctrl.md
BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter NUM_IN, default 10: number of board button/switch inputs, range 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20000: cycles an input must stay stable before it is accepted, range 2..2^20.
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 16: consecutive release cycles required before SD power-up, range 2..2^16.
REQ-004 SHALL have parameter SD_PWR_DELAY, default 1000: cycles from SD power-on to SoC reset release, range 2..2^20.
REQ-005 SHALL use one clock and a reset that is synchronous and active-high: clk_i in 1, the single clock; all logic is on its rising edge.
REQ-006 rst_i in 1: synchronous, active-high reset.
REQ-007 pad_reset_n_i in 1: board reset button, active-low, asynchronous to clk_i.
REQ-008 clk_locked_i in 1: clock generator lock indicator, asynchronous to clk_i.
REQ-009 btn_i in NUM_IN: raw buttons/switches, asynchronous to clk_i.
REQ-010 btn_db_o out NUM_IN: debounced input levels.
REQ-011 btn_rise_o out NUM_IN: one-cycle pulse on each debounced 0->1 transition.
REQ-012 soc_rst_no out 1: SoC reset, active-low.
REQ-013 sd_pwr_no out 1: SD-card power enable, active-low (drives sdio_reset_o).
REQ-014 state_o out 2: sequencer state, for debug: 0=HOLD, 1=SD_PWR, 2=RUN.

Function
REQ-015 SHALL pass btn_i, pad_reset_n_i and clk_locked_i each through a 2-flop synchronizer; "s" below means the second-stage output.
REQ-016 SHALL keep one debounce counter per channel, of width $clog2(DEBOUNCE_CYCLES).
- counter <= 0 whenever s == btn_db_o[i].
- otherwise counter increments each cycle.
- when s != btn_db_o[i] and counter == DEBOUNCE_CYCLES-1: btn_db_o[i] <= s and counter <= 0.
REQ-017 SHALL therefore update btn_db_o[i] exactly 2+DEBOUNCE_CYCLES cycles after a clean pad edge.
REQ-018 SHALL leave btn_db_o unchanged for any glitch that differs at s for fewer than DEBOUNCE_CYCLES consecutive cycles; a single cycle of agreement resets the count.
REQ-019 SHALL assert btn_rise_o[i] for exactly the one cycle after btn_db_o[i] goes 0->1; 1->0 transitions produce no pulse.
REQ-020 SHALL treat channels independently; simultaneous transitions on several channels produce simultaneous pulses.
REQ-021 SHALL implement a reset sequencer FSM "ok" := synced pad_reset_n & synced clk_locked. States and transitions:
- HOLD: hold counter increments while ok and clears when !ok; at count == RST_HOLD_CYCLES-1 with ok, goes to SD_PWR and clears the counter.
- SD_PWR: sd_pwr_no = 0; delay counter increments; at count == SD_PWR_DELAY-1, goes to RUN.
- RUN: soc_rst_no = 1.
- !ok in SD_PWR or RUN: goes to HOLD next cycle and clears all sequencer counters.
REQ-022 SHALL drive soc_rst_no = 1 only in RUN; it SHALL go low in the cycle after the FSM leaves RUN.
REQ-023 SHALL keep sd_pwr_no = 0 once first asserted, including on a return to HOLD; only rst_i removes SD power.
REQ-024 SHALL re-run the full SD_PWR_DELAY wait on every HOLD->SD_PWR transition, even when SD power is already on.
REQ-025 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-026 SHALL, on rst_i high at a clock edge, set:
- all synchronizer flops to 0, so pad reset reads as asserted;
- all counters to 0;
- btn_db_o = 0, btn_rise_o = 0;
- soc_rst_no = 0, sd_pwr_no = 1;
- FSM to HOLD, state_o = 0.
REQ-027 SHALL give rst_i priority over all other events in the same cycle, including a pending debounce update or state transition.

Verification (bench params NUM_IN=4, DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=3, SD_PWR_DELAY=5)
REQ-028 Power-up: deassert rst_i with pad_reset_n_i=1 and clk_locked_i=1 -> sd_pwr_no falls at cycle 2+3, soc_rst_no rises 5 cycles later, state_o sequence 0,1,2.
REQ-029 Debounce: btn_i[2] 0->1 held steady -> btn_db_o[2]=1 exactly 6 cycles later and btn_rise_o[2] pulses once; a 3-cycle glitch on btn_i[1] -> no change.
REQ-030 Mid-run reset: in RUN, drop pad_reset_n_i for 1 cycle -> soc_rst_no=0 within 4 cycles, sd_pwr_no stays 0, RUN is reached again after 3+5 further cycles.
REQ-031 Lock loss in SD_PWR at delay count 3 -> HOLD, delay restarts from 0 after re-lock; soc_rst_no never pulses high.
REQ-032 rst_i in RUN with all 4 buttons pressed -> next cycle all outputs equal their reset values from REQ-026, including sd_pwr_no=1.
